mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store unit between the pipeline MEM stage and the word-addressed data RAM. The RAM has a combinational read and a write on the rising clock edge when its write enable is high.
- Converts byte, halfword and word requests into aligned 32-bit RAM accesses.
- Sub-word stores use read-modify-write. Loads return sign- or zero-extended data.
- Flags misaligned, reserved-size and out-of-range accesses without touching the RAM.

Parameters:
- MEM_WORDS, 102, number of 32-bit words in the RAM; valid word index is 0..MEM_WORDS-1.
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0; word index = (req_addr - BASE_ADDR) >> 2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, reserved size or out of range
- ram_we  out  1  RAM write enable
- ram_addr  out  32  RAM byte address, bits [1:0] forced to 00
- ram_wd  out  32  RAM write data
- ram_rd  in  32  RAM read data, combinational from ram_addr

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_we=0, ram_addr=0, ram_wd=0, all latches 0.
- FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
- ram_we is decoded from state only (high only in WRITE), so reset clears it immediately.
- IDLE: req_ready=1. On req_valid & req_ready, latch addr, size, signed, we and wdata, then branch:
  - Error (size=11; half with addr[0]=1; word with addr[1:0]!=0; word index >= MEM_WORDS or addr < BASE_ADDR) -> RESP with resp_err=1. No RAM write.
  - Load -> LOAD.
  - Word store -> WRITE with ram_wd=wdata.
  - Byte/half store -> MERGE.
- req_ready is 0 in every state except IDLE. Requests offered then are ignored; the pipeline holds them.
- LOAD: ram_addr = latched addr & ~3. Select the lane from ram_rd (byte lane addr[1:0], half lane addr[1], little-endian), extend per signed, register into resp_rdata -> RESP.
- MERGE: same ram_addr. Register ram_rd with the addressed byte/half lane replaced by wdata[7:0]/[15:0]; other lanes unchanged -> WRITE.
- WRITE: ram_we=1, ram_addr held, ram_wd = merged or word data -> RESP. The RAM captures on the edge ending WRITE.
- RESP: resp_valid=1 for exactly one cycle, resp_rdata/resp_err valid -> IDLE. resp_rdata and resp_err clear to 0 on leaving RESP.
- Latency (accept edge = cycle 0): error resp_valid in cycle 1; load and word store in cycle 2; sub-word store in cycle 3.
- No back-to-back acceptance: the next request is accepted at the earliest in the cycle after RESP.
- Reset during MERGE/WRITE: FSM aborts, no write occurs (ram_we low before the next edge), no resp_valid.
- Address arithmetic: 32-bit unsigned; addr < BASE_ADDR counts as out of range, so no wrap-around.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10 -> ram_we=1 in cycle 1 with ram_addr=0x10, resp_valid cycle 2; load word @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
- Byte store RMW: RAM[4]=0x11223344; store byte 0xAA @0x12 -> cycle 1 ram_we=0, cycle 2 ram_wd=0x11AA3344, resp_valid cycle 3.
- Signed/unsigned sub-word loads: RAM[4]=0x8081F0FE. Expected results:
  - lb @0x10 -> 0xFFFFFFFE
  - lbu @0x10 -> 0x000000FE
  - lh @0x12 -> 0xFFFF8081
  - lhu @0x12 -> 0x00008081
- Errors: word load @0x13, half store @0x11, size=11, word @ 102*4=0x198 -> each resp_valid in cycle 1 with resp_err=1, resp_rdata=0, ram_we never asserted.
- Busy handling: hold req_valid=1 with a second store during a sub-word store -> req_ready=0 in cycles 1-3; second request accepted in cycle 4.
- Reset mid-RMW: assert rst during MERGE of a byte store @0x20 -> ram_we stays 0, RAM[8] unchanged, outputs at reset values, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-addressed data RAM.
// Sub-word stores use read-modify-write; loads return sign/zero-extended lanes.
module mem_access_unit #(
   parameter int unsigned MEM_WORDS = 102,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wd,
   input  logic [31:0] ram_rd
);

   typedef enum logic [2:0] {StIdle, StLoad, StMerge, StWrite, StResp} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [31:0] wd_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] word_idx;
   logic        range_err, align_err, req_err;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic [31:0] merged;

   // addr < BASE_ADDR is rejected explicitly so the subtraction never wraps into range
   assign word_idx  = (req_addr - BASE_ADDR) >> 2;
   assign range_err = (req_addr < BASE_ADDR) || (word_idx >= MEM_WORDS);

   always_comb begin
      align_err = 1'b0;
      case (req_size)
         2'b01:   align_err = req_addr[0];
         2'b10:   align_err = |req_addr[1:0];
         2'b11:   align_err = 1'b1;
         default: align_err = 1'b0;
      endcase
   end

   assign req_err = align_err | range_err;

   assign byte_sel = ram_rd[{addr_q[1:0], 3'b000} +: 8];
   assign half_sel = addr_q[1] ? ram_rd[31:16] : ram_rd[15:0];

   always_comb begin
      load_data = ram_rd;
      case (size_q)
         2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
         default: load_data = ram_rd;
      endcase
   end

   always_comb begin
      merged = ram_rd;
      if (size_q == 2'b00) begin
         merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
      end else begin
         merged[{addr_q[1], 4'b0000} +: 16] = wd_q[15:0];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (req_err)                state_d = StResp;
               else if (!req_we)           state_d = StLoad;
               else if (req_size == 2'b10) state_d = StWrite;
               else                        state_d = StMerge;
            end
         end
         StLoad:  state_d = StResp;
         StMerge: state_d = StWrite;
         StWrite: state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         wd_q     <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  addr_q   <= req_addr;
                  size_q   <= req_size;
                  signed_q <= req_signed;
                  err_q    <= req_err;
                  if (req_we) wd_q <= req_wdata;
               end
            end
            StLoad:  rdata_q <= load_data;
            StMerge: wd_q    <= merged;
            StResp: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign ram_we     = (state_q == StWrite);
   assign ram_addr   = {addr_q[31:2], 2'b00};
   assign ram_wd     = wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural RAM and a response scoreboard.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wd;
   logic [31:0] ram_rd;

   mem_access_unit #(.MEM_WORDS(102), .BASE_ADDR(32'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wd     (ram_wd),
      .ram_rd     (ram_rd)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:101];
   int          we_cnt = 0;

   assign ram_rd = (ram_addr[31:2] < 30'd102) ? mem[ram_addr[8:2]] : 32'h0;

   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr[8:2]] <= ram_wd;
         we_cnt <= we_cnt + 1;
      end
   end

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic        we_log   [1:8];
   logic [31:0] wd_log   [1:8];
   logic [31:0] addr_log [1:8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Counts cycles from the accept edge until resp_valid, then scores it against the queue head.
   task automatic wait_resp();
      int   cyc;
      exp_t e;
      for (cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         we_log[cyc]   = ram_we;
         wd_log[cyc]   = ram_wd;
         addr_log[cyc] = ram_addr;
         if (resp_valid) break;
      end
      e = sb.pop_front();
      check({e.tag, ".lat"}, cyc, e.lat);
      check({e.tag, ".rdata"}, resp_rdata, e.rdata);
      check({e.tag, ".err"}, {31'b0, resp_err}, {31'b0, e.err});
      @(negedge clk);
      check({e.tag, ".clr_rdata"}, resp_rdata, 32'h0);
      check({e.tag, ".clr_flags"}, {30'b0, resp_valid, resp_err}, 32'h0);
   endtask

   task automatic req(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                      input logic [31:0] exp_rd, input logic exp_err, input int lat);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      check({tag, ".ready"}, {31'b0, req_ready}, 32'h1);
      sb.push_back('{tag: tag, rdata: exp_rd, err: exp_err, lat: lat});
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_resp();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   n;
      exp_t e;

      #2;
      check("rst.ready", {31'b0, req_ready}, 32'h1);
      check("rst.flags", {29'b0, resp_valid, resp_err, ram_we}, 32'h0);
      check("rst.ram_addr", ram_addr, 32'h0);
      check("rst.ram_wd", ram_wd, 32'h0);
      check("rst.rdata", resp_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // word store then load
      req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, "sw", 32'h0, 1'b0, 2);
      check("sw.we1", {31'b0, we_log[1]}, 32'h1);
      check("sw.addr1", addr_log[1], 32'h10);
      check("sw.wd1", wd_log[1], 32'hDEADBEEF);
      req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw", 32'hDEADBEEF, 1'b0, 2);

      // byte store read-modify-write
      req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, "sw2", 32'h0, 1'b0, 2);
      req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, "sb", 32'h0, 1'b0, 3);
      check("sb.we1", {31'b0, we_log[1]}, 32'h0);
      check("sb.we2", {31'b0, we_log[2]}, 32'h1);
      check("sb.wd2", wd_log[2], 32'h11AA3344);
      check("sb.addr2", addr_log[2], 32'h10);
      req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_sb", 32'h11AA3344, 1'b0, 2);

      // sub-word loads, signed and unsigned
      req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8081F0FE, "sw3", 32'h0, 1'b0, 2);
      req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, "lb", 32'hFFFFFFFE, 1'b0, 2);
      req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, "lbu", 32'h000000FE, 1'b0, 2);
      req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, "lh", 32'hFFFF8081, 1'b0, 2);
      req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "lhu", 32'h00008081, 1'b0, 2);
      req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "lb3", 32'hFFFFFF80, 1'b0, 2);
      req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, "lh0", 32'hFFFFF0FE, 1'b0, 2);

      // errors never touch the RAM
      n = we_cnt;
      req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, "err_mis_w", 32'h0, 1'b1, 1);
      req(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, "err_mis_h", 32'h0, 1'b1, 1);
      req(1'b1, 2'b11, 1'b0, 32'h10, 32'h1234, "err_size", 32'h0, 1'b1, 1);
      req(1'b0, 2'b10, 1'b0, 32'h198, 32'h0, "err_range", 32'h0, 1'b1, 1);
      req(1'b1, 2'b10, 1'b0, 32'h198, 32'h5555, "err_range_st", 32'h0, 1'b1, 1);
      check("err.no_write", we_cnt, n);

      // last valid word
      req(1'b1, 2'b10, 1'b0, 32'h194, 32'h0BADF00D, "sw_last", 32'h0, 1'b0, 2);
      req(1'b0, 2'b10, 1'b0, 32'h194, 32'h0, "lw_last", 32'h0BADF00D, 1'b0, 2);

      // busy: second request held during a sub-word store
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h11; req_wdata = 32'h55;
      sb.push_back('{tag: "busy_sb", rdata: 32'h0, err: 1'b0, lat: 3});
      @(posedge clk);
      #1;
      req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'h12345678;
      sb.push_back('{tag: "busy_sw", rdata: 32'h0, err: 1'b0, lat: 2});
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check($sformatf("busy.ready%0d", c), {31'b0, req_ready}, 32'h0);
      end
      check("busy_sb.valid", {31'b0, resp_valid}, 32'h1);
      e = sb.pop_front();
      check({e.tag, ".rdata"}, resp_rdata, e.rdata);
      check({e.tag, ".err"}, {31'b0, resp_err}, {31'b0, e.err});
      @(negedge clk);
      check("busy.ready4", {31'b0, req_ready}, 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_resp();
      req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_busy1", 32'h808155FE, 1'b0, 2);
      req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, "lw_busy2", 32'h12345678, 1'b0, 2);

      // reset during MERGE aborts the store
      req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, "sw_rst", 32'h0, 1'b0, 2);
      n = we_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h21; req_wdata = 32'h77;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid.we", {31'b0, ram_we}, 32'h0);
      check("rst_mid.ready", {31'b0, req_ready}, 32'h1);
      check("rst_mid.resp", {30'b0, resp_valid, resp_err}, 32'h0);
      check("rst_mid.ram_addr", ram_addr, 32'h0);
      check("rst_mid.ram_wd", ram_wd, 32'h0);
      check("rst_mid.rdata", resp_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid.no_write", we_cnt, n);
      @(negedge clk);
      check("rst_mid.ready_after", {31'b0, req_ready}, 32'h1);
      check("rst_mid.no_resp", {31'b0, resp_valid}, 32'h0);
      req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "lw_rst", 32'hCAFEF00D, 1'b0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
